gpio_input_port: RTL

//  Input-direction GPIO peripheral: samples board switches and buttons, synchronises and debounces them,
//  and presents them to the RV32I core as a small read-only register window with a registered read handshake.

---
 rtl/gpio_input_port.sv | 123 ++++++++++++
 1 files changed

// File: rtl/gpio_input_port.sv
// Input GPIO peripheral: synchronises and debounces switches/buttons, latches press events, and serves a
// registered read-only register window. Optional registered button interrupt under `GPIO_IN_IRQ_EN.
module gpio_input_port #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NUM_SW          = 16,
    parameter int NUM_BTN         = 5
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [NUM_SW-1:0]  SW,
    input  logic [NUM_BTN-1:0] BTN,
    input  logic               rd_en,
    input  logic [1:0]         rd_addr,
    output logic [31:0]        rd_data,
    output logic               rd_valid,
    output logic               btn_irq
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_SW-1:0]  sw_sync1, sw_sync2, sw_stable, sw_stable_nxt;
    logic [NUM_BTN-1:0] btn_sync1, btn_sync2, btn_stable, btn_stable_nxt;
    logic [CW-1:0]      sw_cnt      [NUM_SW];
    logic [CW-1:0]      sw_cnt_nxt  [NUM_SW];
    logic [CW-1:0]      btn_cnt     [NUM_BTN];
    logic [CW-1:0]      btn_cnt_nxt [NUM_BTN];
    logic [NUM_BTN-1:0] btn_event, event_clr, event_nxt;
    logic [31:0]        rd_word;

    // Any sample that agrees with the debounced level restarts the count, so glitches never accumulate.
    always_comb begin
        sw_stable_nxt = sw_stable;
        sw_cnt_nxt    = sw_cnt;
        for (int i = 0; i < NUM_SW; i++) begin
            if (sw_sync2[i] == sw_stable[i]) begin
                sw_cnt_nxt[i] = '0;
            end else if (sw_cnt[i] == CNT_MAX) begin
                sw_stable_nxt[i] = sw_sync2[i];
                sw_cnt_nxt[i]    = '0;
            end else begin
                sw_cnt_nxt[i] = sw_cnt[i] + CW'(1);
            end
        end
    end

    always_comb begin
        btn_stable_nxt = btn_stable;
        btn_cnt_nxt    = btn_cnt;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (btn_sync2[i] == btn_stable[i]) begin
                btn_cnt_nxt[i] = '0;
            end else if (btn_cnt[i] == CNT_MAX) begin
                btn_stable_nxt[i] = btn_sync2[i];
                btn_cnt_nxt[i]    = '0;
            end else begin
                btn_cnt_nxt[i] = btn_cnt[i] + CW'(1);
            end
        end
    end

    // A press landing on the clearing read re-sets its bit: set has priority over clear.
    always_comb begin
        event_clr = (rd_en && rd_addr == 2'd2) ? btn_event : '0;
        event_nxt = (btn_event & ~event_clr) | (btn_stable_nxt & ~btn_stable);
    end

    always_comb begin
        case (rd_addr)
            2'd0:    rd_word = 32'(sw_stable);
            2'd1:    rd_word = 32'(btn_stable);
            2'd2:    rd_word = 32'(btn_event);
            default: rd_word = {30'b0, |btn_event, |btn_stable};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sw_sync1   <= '0;
            sw_sync2   <= '0;
            sw_stable  <= '0;
            btn_sync1  <= '0;
            btn_sync2  <= '0;
            btn_stable <= '0;
            btn_event  <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            for (int i = 0; i < NUM_SW; i++) begin
                sw_cnt[i] <= '0;
            end
            for (int i = 0; i < NUM_BTN; i++) begin
                btn_cnt[i] <= '0;
            end
        end else begin
            sw_sync1   <= SW;
            sw_sync2   <= sw_sync1;
            sw_stable  <= sw_stable_nxt;
            sw_cnt     <= sw_cnt_nxt;
            btn_sync1  <= BTN;
            btn_sync2  <= btn_sync1;
            btn_stable <= btn_stable_nxt;
            btn_cnt    <= btn_cnt_nxt;
            btn_event  <= event_nxt;
            rd_valid   <= rd_en;
            if (rd_en) begin
                rd_data <= rd_word;
            end
        end
    end

`ifdef GPIO_IN_IRQ_EN
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            btn_irq <= 1'b0;
        end else begin
            btn_irq <= |event_nxt;
        end
    end
`else
    assign btn_irq = 1'b0;
`endif

endmodule
